// File: rtl/sw_pe_unit.sv
// rtl/sw_pe_unit.sv - Smith-Waterman systolic processing element (linear gap)
//
// Purpose: computes one DP row of a local alignment. Each valid target base Y
// produces H = max(0, diag+s, top-GAP, left-GAP), clamped to an unsigned
// SCORE_W result that saturates instead of wrapping.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   X_i      in   [1:0]         query base owned by this PE (A=0,C=1,G=2,T=3)
//   Y_i      in   [1:0]         target base for this cycle
//   valid_i  in                 Y_i/top_i valid this cycle
//   top_i    in   [SCORE_W-1:0] H[i-1][j] from the previous PE
//   score_o  out  [SCORE_W-1:0] registered H[i][j]
//   Y_o      out  [1:0]         Y_i delayed one cycle
//   valid_o  out                valid_i delayed one cycle

module sw_pe_unit #(
  parameter int SCORE_W  = 16,
  parameter int MATCH    = 2,
  parameter int MISMATCH = 1,
  parameter int GAP      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         X_i,
  input  logic [1:0]         Y_i,
  input  logic               valid_i,
  input  logic [SCORE_W-1:0] top_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [1:0]         Y_o,
  output logic               valid_o
);

  // Two extra bits: one for sign, one for headroom above 2^SCORE_W-1.
  localparam int EW = SCORE_W + 2;
  localparam logic signed [EW-1:0] SAT_MAX = EW'({SCORE_W{1'b1}});

  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_diag;
  logic [1:0]         r_y;
  logic               r_valid;

  logic signed [EW-1:0] w_s;
  logic signed [EW-1:0] w_diag;
  logic signed [EW-1:0] w_top;
  logic signed [EW-1:0] w_left;
  logic signed [EW-1:0] w_max;
  logic [SCORE_W-1:0]   w_h;

  always_comb begin
    w_s    = (X_i == Y_i) ? EW'(MATCH) : -EW'(MISMATCH);
    w_diag = $signed({2'b00, r_diag})  + w_s;
    w_top  = $signed({2'b00, top_i})   - EW'(GAP);
    w_left = $signed({2'b00, r_score}) - EW'(GAP);

    // Starting from zero gives the local-alignment clamp for free.
    w_max = '0;
    if (w_diag > w_max) w_max = w_diag;
    if (w_top  > w_max) w_max = w_top;
    if (w_left > w_max) w_max = w_left;

    if (w_max > SAT_MAX) w_h = {SCORE_W{1'b1}};
    else                 w_h = w_max[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
      r_diag  <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_y     <= Y_i;
      r_valid <= valid_i;
      if (valid_i) begin
        r_score <= w_h;
        r_diag  <= top_i;
      end
    end
  end

  assign score_o = r_score;
  assign Y_o     = r_y;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_sw_pe_unit.sv
// tb/tb_sw_pe_unit.sv - directed self-checking bench for sw_pe_unit

module tb_sw_pe_unit;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    x0, x1;
  logic [1:0]    y_in;
  logic          v_in;
  logic [SW-1:0] top_in;

  logic [SW-1:0] score0, score1;
  logic [1:0]    y0, y1;
  logic          v0, v1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sw_pe_unit #(.SCORE_W(SW), .MATCH(2), .MISMATCH(1), .GAP(1)) u_pe0 (
    .clk(clk), .rst(rst), .X_i(x0), .Y_i(y_in), .valid_i(v_in),
    .top_i(top_in), .score_o(score0), .Y_o(y0), .valid_o(v0)
  );

  sw_pe_unit #(.SCORE_W(SW), .MATCH(2), .MISMATCH(1), .GAP(1)) u_pe1 (
    .clk(clk), .rst(rst), .X_i(x1), .Y_i(y0), .valid_i(v0),
    .top_i(score0), .score_o(score1), .Y_o(y1), .valid_o(v1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] y, input logic [SW-1:0] t);
    v_in = v; y_in = y; top_in = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, '0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; x0 = 2'd0; x1 = 2'd1;
    drive(1'b0, 2'd0, '0);
    step();
    chk("rst_score", 32'(score0), 32'h0);
    chk("rst_yo",    32'(y0),     32'h0);
    chk("rst_vo",    32'(v0),     32'h0);
    rst = 1'b0;

    // Asynchronous reset lands between edges.
    x0 = 2'd0;
    drive(1'b1, 2'd3, 16'd7);          // mismatch; top-1 = 6 wins
    step();
    chk("pre_arst_score", 32'(score0), 32'd6);
    chk("pre_arst_yo",    32'(y0),     32'd3);
    #3 rst = 1'b1;
    #1;
    chk("arst_score", 32'(score0), 32'h0);
    chk("arst_yo",    32'(y0),     32'h0);
    chk("arst_vo",    32'(v0),     32'h0);
    step();
    rst = 1'b0;

    // Single PE, X=A, stream A,A,C,C with top=0 -> 2,2,1,0
    do_reset();
    x0 = 2'd0;
    drive(1'b1, 2'd0, '0); step();
    chk("seq0", 32'(score0), 32'd2);
    chk("seq0_yo", 32'(y0), 32'd0);
    chk("seq0_vo", 32'(v0), 32'd1);
    drive(1'b1, 2'd0, '0); step();
    chk("seq1", 32'(score0), 32'd2);
    drive(1'b1, 2'd1, '0); step();
    chk("seq2", 32'(score0), 32'd1);
    chk("seq2_yo", 32'(y0), 32'd1);
    drive(1'b1, 2'd1, '0); step();
    chk("seq3", 32'(score0), 32'd0);
    drive(1'b0, 2'd2, '0); step();
    chk("seq_end_vo", 32'(v0), 32'd0);
    chk("seq_end_yo", 32'(y0), 32'd2);

    // Two chained PEs: X0=A, X1=C, stream A,C
    do_reset();
    x0 = 2'd0; x1 = 2'd1;
    drive(1'b1, 2'd0, '0); step();
    chk("chain_pe0_j0", 32'(score0), 32'd2);
    chk("chain_pe1_idle", 32'(score1), 32'd0);
    drive(1'b1, 2'd1, '0); step();
    chk("chain_pe0_j1", 32'(score0), 32'd1);
    chk("chain_pe1_j0", 32'(score1), 32'd1);
    drive(1'b0, 2'd0, '0); step();
    chk("chain_pe0_hold", 32'(score0), 32'd1);
    chk("chain_pe1_j1", 32'(score1), 32'd4);
    chk("chain_pe1_yo", 32'(y1), 32'd1);

    // Saturation, X=G
    do_reset();
    x0 = 2'd2;
    drive(1'b1, 2'd3, 16'hFFFF); step();
    chk("sat_top_gap", 32'(score0), 32'hFFFE);
    drive(1'b1, 2'd2, 16'h0000); step();
    chk("sat_clip", 32'(score0), 32'hFFFF);
    drive(1'b1, 2'd2, 16'h0000); step();   // diag=0 now; left-1 = FFFE
    chk("sat_after", 32'(score0), 32'hFFFE);

    // Valid gap: state holds while inputs wiggle
    do_reset();
    x0 = 2'd0;
    drive(1'b1, 2'd0, '0); step();
    chk("gap_start", 32'(score0), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'(i + 1), 16'd50 + 16'(i));
      step();
      chk("gap_hold", 32'(score0), 32'd2);
      chk("gap_vo", 32'(v0), 32'd0);
    end
    drive(1'b1, 2'd0, 16'd3); step();     // diag 0+2=2, top-1=2, left-1=1
    chk("gap_resume", 32'(score0), 32'd2);

    // Reset mid-stream restarts at j=0
    do_reset();
    x0 = 2'd0;
    drive(1'b1, 2'd0, 16'd10); step();
    chk("mid_a", 32'(score0), 32'd9);
    drive(1'b1, 2'd0, 16'd0); step();
    chk("mid_b", 32'(score0), 32'd12);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("mid_rst", 32'(score0), 32'd0);
    drive(1'b1, 2'd0, 16'd0); step();
    chk("mid_fresh", 32'(score0), 32'd2);

    // Reset wins over a simultaneous valid input
    rst = 1'b1;
    drive(1'b1, 2'd0, 16'd20); step();
    chk("rst_wins_score", 32'(score0), 32'd0);
    chk("rst_wins_vo", 32'(v0), 32'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/sw_pe_unit.md
Name: sw_pe_unit

Overview:
- One processing element (PE) of a linear systolic Smith-Waterman local-alignment array with linear gap penalty.
- Each PE owns one fixed query base X and computes one DP row while target bases Y stream through the chain, one per clock.
- Neighbouring PEs connect Y_o→Y_i, valid_o→valid_i and score_o→top_i; the first PE has top_i tied to 0.

Parameters:
- SCORE_W, 16, width of top_i/score_o; unsigned scores.
- MATCH, 2, added when X_i == Y_i.
- MISMATCH, 1, subtracted when X_i != Y_i.
- GAP, 1, subtracted for a gap from top or left.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- X_i  in  2  query base held by this PE, static during a run. Encoding: A=00, C=01, G=10, T=11.
- Y_i  in  2  target base arriving this cycle.
- valid_i  in  1  Y_i/top_i are valid this cycle.
- top_i  in  SCORE_W  H[i-1][j] from the previous PE (0 for the first PE).
- score_o  out  SCORE_W  registered H[i][j].
- Y_o  out  2  Y_i delayed one cycle.
- valid_o  out  1  valid_i delayed one cycle.

Behaviour:
- Reset (asynchronous, rst=1): score_o=0, Y_o=0, valid_o=0, internal diag register=0. All hold at 0 while rst is high.
- Every rising edge (rst=0): Y_o<=Y_i and valid_o<=valid_i, unconditionally.
- Internal state:
  - diag = top_i captured on the last valid cycle, i.e. H[i-1][j-1].
  - left = the current score_o, i.e. H[i][j-1].
- On a rising edge with valid_i=1:
  - s = +MATCH if X_i==Y_i, else -MISMATCH.
  - H = max(0, diag+s, top_i-GAP, left-GAP).
  - score_o<=H, and diag<=top_i.
- Arithmetic:
  - Evaluate in signed, at least SCORE_W+2 bits.
  - Clamp below at 0.
  - Saturate above at 2^SCORE_W-1 (16'hFFFF); never wrap.
- valid_i=0: score_o and diag hold their values; valid_o<=0.
- Latency: 1 cycle per PE. For Y_j entering PE0 at edge t, PE k presents H[k][j] on score_o after edge t+k (k=0 is PE0).
- Simultaneous rst and valid_i: rst wins.
- Reset mid-stream: all state clears immediately. The next valid Y is treated as j=0 (diag=0, left=0).
- No maximum tracking inside the PE. score_o is the raw cell value.
- Purely synchronous datapath: one comparator, three adders, a 4-way max with 0-clamp, and registers.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle → score_o=0, Y_o=0, valid_o=0 immediately, without waiting for an edge.
2. Single PE, X=A, top_i=0, valid=1, Y stream A,A,C,C → score_o sequence 2,2,1,0. Y_o and valid_o echo the inputs one cycle late.
3. Two chained PEs, X0=A, X1=C, Y stream A,C → PE0 gives 2,1. PE1, one cycle later, gives 1 then 4 (diag 2 + match 2).
4. Saturation, single PE X=G:
   - Apply top_i=16'hFFFF with Y=T (mismatch) → score_o=16'hFFFE (top−gap).
   - Then top_i=0, Y=G (match) → score_o=16'hFFFF (diag+2 saturates, no wrap).
5. Valid gap: after the score reaches 2, drop valid_i for 3 cycles while toggling Y_i/top_i → score_o holds 2 and valid_o=0. Resuming with a match continues from the held diag/left.
6. Reset mid-stream: after a nonzero score, pulse rst, then resume with Y=A, X=A, top_i=0 → score_o=2 (fresh j=0), not the previous accumulated value.
